// File: rtl/ntt_pkg.sv
// Shared types and helpers for the SDF NTT stage controller.
package ntt_pkg;

  typedef enum logic [2:0] {IDLE, FILL, BFLY, SHIFT, DRAIN} ntt_sdf_state_t;

  localparam int unsigned DefaultN = 256;

  // Delay-buffer depth of an SDF stage.
  function automatic int unsigned sdf_delay(int unsigned n, int unsigned stage);
    return n >> (stage + 1);
  endfunction

endpackage

// File: rtl/ntt_phase_cnt.sv
// Wrapping modulo-Mod phase counter with enable, synchronous clear and last-value flag.
module ntt_phase_cnt #(
  parameter int unsigned Mod = 2,
  parameter int unsigned CW  = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);

  assign last_o = (cnt_o == CW'(Mod - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      cnt_o <= last_o ? '0 : cnt_o + CW'(1);
    end
  end

endmodule

// File: rtl/ntt_sdf_ctrl.sv
// Sequencing controller for one SDF NTT stage: buffer advance, butterfly select, twiddle address.
// Optional perf counters (frame_cnt, stall_cnt) are enabled by defining NTT_CTRL_PERF_EN.
module ntt_sdf_ctrl
  import ntt_pkg::*;
#(
  parameter int unsigned N     = DefaultN,
  parameter int unsigned STAGE = 0,
  localparam int unsigned LOG2N = $clog2(N),
  localparam int unsigned D     = sdf_delay(N, STAGE),
  localparam int unsigned CW    = ($clog2(2 * D) > 1) ? $clog2(2 * D) : 1,
  localparam int unsigned TW    = (LOG2N > 2) ? LOG2N - 1 : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic          buf_en,
  output logic          bf_sel,
  output logic [TW-1:0] tw_addr,
  output logic          out_valid,
  output logic          frame_done,
  output logic          busy
`ifdef NTT_CTRL_PERF_EN
  ,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   stall_cnt
`endif
);

  ntt_sdf_state_t state_q;
  logic [CW-1:0]  cnt;
  logic           cnt_last;
  logic           flush_q;
  logic           in_drain, accept, half_last, flush_set, flush_eff, run_state;

  always_comb begin
    in_drain  = (state_q == DRAIN);
    run_state = (state_q == FILL) || (state_q == BFLY) || (state_q == SHIFT);
    accept    = in_valid & ~in_drain;
    half_last = (cnt == CW'(D - 1));
    // A flush in IDLE has no frame to attach to, so only running states latch it.
    flush_set = flush & run_state;
    flush_eff = flush_q | flush_set;
  end

  assign in_ready = ~in_drain;
  assign busy     = (state_q != IDLE);

  ntt_phase_cnt #(
    .Mod (2 * D),
    .CW  (CW)
  ) u_phase_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (accept | in_drain),
    .clr_i  (in_drain & half_last),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      flush_q    <= 1'b0;
      buf_en     <= 1'b0;
      bf_sel     <= 1'b0;
      tw_addr    <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // Stall default: bf_sel and tw_addr keep their last value.
      buf_en     <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (flush_set) flush_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            buf_en  <= 1'b1;
            bf_sel  <= 1'b0;
            tw_addr <= '0;
            state_q <= (D == 1) ? BFLY : FILL;
          end
        end
        FILL: begin
          if (accept) begin
            buf_en  <= 1'b1;
            bf_sel  <= 1'b0;
            tw_addr <= '0;
            if (half_last) state_q <= BFLY;
          end
        end
        BFLY: begin
          if (accept) begin
            buf_en    <= 1'b1;
            bf_sel    <= 1'b1;
            out_valid <= 1'b1;
            tw_addr   <= TW'((32'(cnt) - D) << STAGE);
            if (cnt_last) begin
              frame_done <= 1'b1;
              if (flush_eff) begin
                state_q <= DRAIN;
                flush_q <= 1'b0;
              end else begin
                state_q <= SHIFT;
              end
            end
          end
        end
        SHIFT: begin
          if (accept) begin
            buf_en    <= 1'b1;
            bf_sel    <= 1'b0;
            out_valid <= 1'b1;
            tw_addr   <= '0;
            if (half_last) state_q <= BFLY;
          end
        end
        DRAIN: begin
          buf_en    <= 1'b1;
          bf_sel    <= 1'b0;
          out_valid <= 1'b1;
          tw_addr   <= '0;
          if (half_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef NTT_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (frame_done && (frame_cnt != 16'hFFFF)) frame_cnt <= frame_cnt + 16'd1;
      if (run_state && !in_valid && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ntt_sdf_ctrl.sv
// Directed table-driven bench for ntt_sdf_ctrl (N=8, STAGE=0 and STAGE=2 instances).
module tb_ntt_sdf_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, iv0, fl0, rdy0, be0, bs0, ov0, fd0, busy0;
  logic rst1, iv1, fl1, rdy1, be1, bs1, ov1, fd1, busy1;
  logic [1:0] tw0, tw1;
`ifdef NTT_CTRL_PERF_EN
  logic [15:0] fc0, sc0, fc1, sc1;
`endif

  ntt_sdf_ctrl #(.N(8), .STAGE(0)) dut0 (
    .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(rdy0), .flush(fl0),
    .buf_en(be0), .bf_sel(bs0), .tw_addr(tw0), .out_valid(ov0),
    .frame_done(fd0), .busy(busy0)
`ifdef NTT_CTRL_PERF_EN
    , .frame_cnt(fc0), .stall_cnt(sc0)
`endif
  );

  ntt_sdf_ctrl #(.N(8), .STAGE(2)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(rdy1), .flush(fl1),
    .buf_en(be1), .bf_sel(bs1), .tw_addr(tw1), .out_valid(ov1),
    .frame_done(fd1), .busy(busy1)
`ifdef NTT_CTRL_PERF_EN
    , .frame_cnt(fc1), .stall_cnt(sc1)
`endif
  );

  typedef struct packed {
    logic       rst, iv, fl;
    logic       be, bs, ov, fd;
    logic [1:0] tw;
    logic       chk_bs, chk_tw;
    logic       rdy, busy;
  } vec_t;

  vec_t t0[$];
  vec_t t1[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input logic rst, iv, fl, be, bs, ov, fd, input logic [1:0] tw,
                              input logic cbs, ctw, rdy, busy);
    vec_t v;
    v = '{rst: rst, iv: iv, fl: fl, be: be, bs: bs, ov: ov, fd: fd, tw: tw,
          chk_bs: cbs, chk_tw: ctw, rdy: rdy, busy: busy};
    return v;
  endfunction

  task automatic push_reset(input logic iv);
    t0.push_back(mk(1, iv, 0, 0, 0, 0, 0, 2'd0, 1, 1, 1, 0));
  endtask

  // D=4 sample k of a frame: k<4 shift/fill half, k>=4 butterfly half with tw = k-4.
  task automatic push_sample(input int k, input bit first, input bit fl, input bit drains);
    bit hi;
    hi = (k >= 4);
    t0.push_back(mk(0, 1, fl, 1, hi, hi | !first, (k == 7), hi ? 2'(k - 4) : 2'd0,
                    1, hi, !(k == 7 && drains), 1));
  endtask

  task automatic push_frame(input bit first, input int flush_at, input bit drains);
    for (int k = 0; k < 8; k++) push_sample(k, first, (k == flush_at), drains);
  endtask

  task automatic push_drain(input int flush_at, input logic iv);
    for (int d = 0; d < 4; d++)
      t0.push_back(mk(0, iv, (d == flush_at), 1, 0, 1, 0, 2'd0, 1, 0, (d == 3), (d != 3)));
  endtask

  task automatic chk(input int idx, input string name, input logic [1:0] act, exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL vec %0d %s: got %0h expected %0h", idx, name, act, exp);
    end
  endtask

  task automatic apply(input bit sel, input vec_t v, input int idx);
    logic       a_be, a_bs, a_ov, a_fd, a_rdy, a_busy;
    logic [1:0] a_tw;
    if (!sel) begin
      rst0 = v.rst; iv0 = v.iv; fl0 = v.fl;
    end else begin
      rst1 = v.rst; iv1 = v.iv; fl1 = v.fl;
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (!sel) begin
      a_be = be0; a_bs = bs0; a_ov = ov0; a_fd = fd0; a_tw = tw0; a_rdy = rdy0; a_busy = busy0;
    end else begin
      a_be = be1; a_bs = bs1; a_ov = ov1; a_fd = fd1; a_tw = tw1; a_rdy = rdy1; a_busy = busy1;
    end
    chk(idx, "buf_en", {1'b0, a_be}, {1'b0, v.be});
    if (v.chk_bs) chk(idx, "bf_sel", {1'b0, a_bs}, {1'b0, v.bs});
    chk(idx, "out_valid", {1'b0, a_ov}, {1'b0, v.ov});
    chk(idx, "frame_done", {1'b0, a_fd}, {1'b0, v.fd});
    if (v.chk_tw) chk(idx, "tw_addr", a_tw, v.tw);
    chk(idx, "in_ready", {1'b0, a_rdy}, {1'b0, v.rdy});
    chk(idx, "busy", {1'b0, a_busy}, {1'b0, v.busy});
  endtask

  initial begin
    rst0 = 1; iv0 = 0; fl0 = 0;
    rst1 = 1; iv1 = 0; fl1 = 0;

    // 1: single frame from reset.
    push_reset(0);
    push_frame(1, -1, 0);
    // 2: two-cycle stall after sample 5; tw_addr holds at 1.
    push_reset(0);
    for (int k = 0; k < 6; k++) push_sample(k, 1, 0, 0);
    t0.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd1, 0, 1, 1, 1));
    t0.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd1, 0, 1, 1, 1));
    for (int k = 6; k < 8; k++) push_sample(k, 1, 0, 0);
    // 3: two back-to-back frames, second opens in SHIFT.
    push_reset(0);
    push_frame(1, -1, 0);
    push_frame(0, -1, 0);
    // 4: flush during FILL, drain, idle, then a clean restart.
    push_reset(0);
    push_frame(1, 2, 1);
    push_drain(-1, 0);
    t0.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 0));
    push_frame(1, -1, 0);
    // 4b: flush on last BFLY sample; flush inside DRAIN and in IDLE is ignored.
    push_reset(0);
    push_frame(1, 7, 1);
    push_drain(1, 1);
    push_frame(1, -1, 0);
    push_reset(0);
    t0.push_back(mk(0, 0, 1, 0, 0, 0, 0, 2'd0, 1, 1, 1, 0));
    push_frame(1, -1, 0);
    // 5: reset with in_valid during BFLY sample 5, then a fresh frame.
    push_reset(0);
    for (int k = 0; k < 5; k++) push_sample(k, 1, 0, 0);
    push_reset(1);
    push_frame(1, -1, 0);

    // 6: D=1 instance.
    t1.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 1, 1, 1, 0));
    t1.push_back(mk(0, 1, 0, 1, 0, 0, 0, 2'd0, 1, 0, 1, 1));
    for (int p = 0; p < 2; p++) begin
      t1.push_back(mk(0, 1, 0, 1, 1, 1, 1, 2'd0, 1, 1, 1, 1));
      t1.push_back(mk(0, 1, 0, 1, 0, 1, 0, 2'd0, 1, 0, 1, 1));
    end
    t1.push_back(mk(0, 1, 0, 1, 1, 1, 1, 2'd0, 1, 1, 1, 1));

    for (int i = 0; i < t0.size(); i++) apply(0, t0[i], i);
    rst0 = 1; iv0 = 0; fl0 = 0;
    for (int i = 0; i < t1.size(); i++) apply(1, t1[i], 1000 + i);
    iv1 = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
